// File: rtl/ulisp_periph_pkg.sv
// Shared definitions for ulisp bus peripherals: register offsets,
// status bit positions and the serial FSM state encodings.
package ulisp_periph_pkg;

    localparam int REG_DATA   = 0;
    localparam int REG_STATUS = 1;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_AVAIL  = 2;
    localparam int ST_TX_OVR    = 3;
    localparam int ST_RX_OVR    = 4;
    localparam int ST_FRAME_ERR = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ulisp_sync_fifo.sv
// Single-clock FIFO. Push and pop in the same cycle are both honoured;
// a push into a full FIFO lands only if a pop frees a slot that cycle.
module ulisp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array, no reset needed since empty slots are never read out
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ulisp_uart.sv
// Memory-mapped 8N1 serial console with TX/RX FIFOs and sticky status.
//
// TX FSM state | meaning
//   TX_IDLE    | line idle, waiting for a byte in the TX FIFO
//   TX_START   | driving start bit (0)
//   TX_DATA    | driving 8 data bits, LSB first
//   TX_STOP    | driving stop bit (1), then next byte or idle
// RX FSM state | meaning
//   RX_IDLE    | waiting for a falling edge on the synchronised line
//   RX_START   | half-bit wait, confirm start bit is still low
//   RX_DATA    | sampling 8 data bits at mid-bit
//   RX_STOP    | sampling stop bit, push byte or flag framing error
module ulisp_uart
    import ulisp_periph_pkg::*;
#(
    parameter int BASE_INDEX     = 0,
    parameter int CLOCKS_PER_BIT = 16,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int              CNT_W     = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [6:0]       DATA_IDX  = 7'(BASE_INDEX + REG_DATA);
    localparam logic [6:0]       STAT_IDX  = 7'(BASE_INDEX + REG_STATUS);

    logic hit_data, hit_status, wr_data, rd_data, wr_status;
    logic unused_write_hi;

    logic       tx_full, tx_fifo_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_push;
    logic [7:0] rx_head;

    tx_state_t        tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [7:0]       tx_shift, tx_shift_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic             tx_tc;

    rx_state_t        rx_state, rx_state_d;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
    logic [7:0]       rx_shift, rx_shift_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic             rx_tc, rx_ferr;
    logic             rx_meta, rx_sync, rx_prev;

    logic tx_ovr, rx_ovr, frame_err;
    logic tx_ovr_set, rx_ovr_set;
    logic [15:0] status_word;

    assign hit_data   = (register_index == DATA_IDX);
    assign hit_status = (register_index == STAT_IDX);
    assign wr_data    = register_write && hit_data;
    assign rd_data    = register_read && hit_data;
    assign wr_status  = register_write && hit_status;

    // Upper data byte has no meaning for a byte-wide console
    assign unused_write_hi = ^register_write_value[15:8];

    ulisp_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_data),
        .pop     (tx_pop),
        .din     (register_write_value[7:0]),
        .dout    (tx_head),
        .full    (tx_full),
        .empty   (tx_fifo_empty)
    );

    ulisp_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (rd_data),
        .din     (rx_shift),
        .dout    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign tx_tc = (tx_cnt == '0);
    assign rx_tc = (rx_cnt == '0);
    assign irq   = !rx_empty;

    // Drops happen only when the FIFO stays full through the cycle
    assign tx_ovr_set = wr_data && tx_full && !tx_pop;
    assign rx_ovr_set = rx_push && rx_full && !rd_data;

    // TX state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_shift <= tx_shift_d;
            tx_bit   <= tx_bit_d;
        end
    end

    // TX next-state: down-counter paces each bit, STOP chains straight into START
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_shift_d = tx_shift;
        tx_bit_d   = tx_bit;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = BIT_LOAD;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tc) begin
                    tx_cnt_d   = BIT_LOAD;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tc) begin
                    tx_cnt_d = BIT_LOAD;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        tx_bit_d   = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tc) begin
                    if (!tx_fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_cnt_d   = BIT_LOAD;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Registered serial output keeps the line glitch-free; reset forces idle-high at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uart_tx <= 1'b1;
        end else begin
            case (tx_state)
                TX_START: uart_tx <= 1'b0;
                TX_DATA:  uart_tx <= tx_shift[0];
                default:  uart_tx <= 1'b1;
            endcase
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_shift <= rx_shift_d;
            rx_bit   <= rx_bit_d;
        end
    end

    // RX next-state: half-bit wait to centre on the start bit, then full-bit steps
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_shift_d = rx_shift;
        rx_bit_d   = rx_bit;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_cnt_d   = HALF_LOAD;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (rx_sync) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_cnt_d   = BIT_LOAD;
                        rx_bit_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    rx_cnt_d   = BIT_LOAD;
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                    else                rx_bit_d   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_tc) begin
                    if (rx_sync) rx_push = 1'b1;
                    else         rx_ferr = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Sticky error bits: write-1-to-clear, a same-cycle set takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovr    <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (tx_ovr_set)                                        tx_ovr <= 1'b1;
            else if (wr_status && register_write_value[ST_TX_OVR]) tx_ovr <= 1'b0;
            if (rx_ovr_set)                                        rx_ovr <= 1'b1;
            else if (wr_status && register_write_value[ST_RX_OVR]) rx_ovr <= 1'b0;
            if (rx_ferr)                                              frame_err <= 1'b1;
            else if (wr_status && register_write_value[ST_FRAME_ERR]) frame_err <= 1'b0;
        end
    end

    // Status word and combinational read mux
    always_comb begin
        status_word               = '0;
        status_word[ST_TX_FULL]   = tx_full;
        status_word[ST_TX_EMPTY]  = tx_fifo_empty && (tx_state == TX_IDLE);
        status_word[ST_RX_AVAIL]  = !rx_empty;
        status_word[ST_TX_OVR]    = tx_ovr;
        status_word[ST_RX_OVR]    = rx_ovr;
        status_word[ST_FRAME_ERR] = frame_err;

        register_read_value = '0;
        if (reset_n && register_read) begin
            if (hit_data)        register_read_value = {8'h00, rx_empty ? 8'h00 : rx_head};
            else if (hit_status) register_read_value = status_word;
        end
    end

endmodule

// File: doc/ulisp_uart.md
Name: ulisp_uart

Overview:
- Memory-mapped serial console peripheral on the ulisp register bus (register_index / register_read / register_write).
- Successor to the bench-side "write register 0 prints a character" console.
- Adds parametrised TX/RX FIFOs, real 8N1 serial framing, a receive path and a status register with sticky error bits.
- Sits beside data memory in the ulisp top level; multiple instances are distinguished by BASE_INDEX.

Parameters:
- BASE_INDEX, 0: register index of the DATA register; STATUS is BASE_INDEX+1.
- CLOCKS_PER_BIT, 16: clk cycles per serial bit; minimum 4.
- TX_DEPTH, 8: TX FIFO entries; power of two, minimum 2.
- RX_DEPTH, 8: RX FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- register_index  in  7  bus register address.
- register_read  in  1  read strobe, one cycle.
- register_write  in  1  write strobe, one cycle.
- register_write_value  in  16  write data.
- register_read_value  out  16  read data.
- uart_rx  in  1  serial input, asynchronous to clk.
- uart_tx  out  1  serial output, idle high.
- irq  out  1  high while the RX FIFO is non-empty.

Behaviour:
- Reset (async, reset_n=0):
  - uart_tx=1, irq=0, register_read_value=0.
  - Both FIFOs empty; all sticky bits 0; TX and RX FSMs in IDLE.
  - Reset mid-frame aborts the frame immediately; uart_tx returns high the same instant.
- Register decode:
  - Combinational read: register_read_value = selected register when register_index hits and register_read=1; otherwise 0.
  - Side effects (pops, clears) occur at the clk edge ending the strobe cycle.
- DATA write: pushes register_write_value[7:0] into the TX FIFO; bits 15:8 are ignored. If the FIFO is full, the byte is dropped and TX_OVR is set.
- DATA read:
  - Returns {8'h00, RX head}. If empty, returns 0 and nothing is popped.
  - Otherwise the head is popped at the edge.
- STATUS read returns:
  - bit0 TX_FULL, bit1 TX_EMPTY (FIFO empty and TX FSM idle).
  - bit2 RX_AVAIL.
  - bit3 TX_OVR, bit4 RX_OVR, bit5 FRAME_ERR.
  - Other bits 0.
- STATUS write: a 1 in bit3, bit4 or bit5 clears that sticky bit (write-1-to-clear). If a set event occurs in the same cycle as the clear, set wins.
- register_read and register_write asserted together: the write is performed and read data is still driven; this is a legal but unused case.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty: pop the head into the shift register and go to START on the next edge.
  - Each state holds for CLOCKS_PER_BIT cycles.
  - START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
  - STOP goes to IDLE, or directly to START if the FIFO is non-empty. Back-to-back frames have no extra idle bit.
  - First-byte latency: uart_tx falls 2 cycles after the write edge.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a falling edge on the synchronised input moves to START.
  - START: re-sample at CLOCKS_PER_BIT/2. If high, it was a glitch; return to IDLE with nothing pushed.
  - DATA: sample each bit every CLOCKS_PER_BIT at mid-bit.
  - STOP: sample the stop bit. If high, push the byte; if the FIFO is full, drop the byte and set RX_OVR. If low, set FRAME_ERR and discard the byte.
  - After STOP, return to IDLE; a new start bit is detected from there.
- FIFOs:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot) and when it is empty (the push lands; the pop is ignored).
  - Pointers wrap modulo depth. Count is $clog2(DEPTH)+1 bits wide.
- Counters: the bit-timing counter is $clog2(CLOCKS_PER_BIT) bits; the bit index is 3 bits.

Decomposition:
- Package ulisp_periph_pkg holds:
  - register offsets: REG_DATA=0, REG_STATUS=1;
  - status bit positions;
  - the TX and RX FSM state enums.
- Sub-module: ulisp_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty).
- It is instantiated twice, once for TX and once for RX.

Test Plan:
All scenarios use CLOCKS_PER_BIT=4, TX_DEPTH=RX_DEPTH=4, BASE_INDEX=0.
1. Write 0x0041 to index 0 -> uart_tx low 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; STATUS reads 0x0002 afterwards.
2. Write 6 bytes back-to-back -> 5 are transmitted (4 in the FIFO, 1 popped early), the 6th is dropped, STATUS bit3=1; write 0x0008 to STATUS -> bit3=0.
3. Drive a 0x5A frame on uart_rx -> irq=1, STATUS bit2=1; read index 0 returns 0x005A; irq=0 the next cycle.
4. Drive 5 RX frames with no reads -> RX_OVR=1; reads return the first 4 bytes in order, then 0x0000.
5. Hold the stop bit low on an RX frame -> FRAME_ERR=1 and nothing is pushed. A 1-cycle low glitch on idle uart_rx -> no push, no error.
6. Deassert reset_n mid-TX-frame -> uart_tx=1 immediately; status=0x0002 after release; no residual bits are transmitted.
